alu_issue_unit: RTL

Execute-stage issuer for `alu_32`. It accepts one decoded MIPS instruction at a time over a valid/ready handshake and maps opcode/funct to the 4-bit ALU control code. It drives the ALU operand/control inputs from registers, captures the ALU result and flags, and returns them over a second valid/ready handshake. It also owns the HI/LO registers and runs a 32-cycle unsigned multiply (MULTU) internally. It sits between decode/register-read and writeback in the multi-cycle datapath.

---
 rtl/alu_issue_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Execute-stage issuer for alu_32: decodes one instruction per handshake, drives the ALU
// from registers, returns result/flags, and owns HI/LO with a 32-cycle shift-add MULTU.
module alu_issue_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic [31:0] alu_s,
    output logic [31:0] alu_t,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_illegal,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_MUL = 2'd1;
    localparam logic [1:0] K_ILL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] alu_s_q, alu_s_d, alu_t_q, alu_t_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [31:0] mplier_q, mplier_d;

    logic [1:0]  dec_kind;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_s, dec_t;
    logic [31:0] imm_sext, imm_zext;
    logic [63:0] prod_step;
    logic        accept;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign imm_sext  = {{16{imm[15]}}, imm};
    assign imm_zext  = {16'h0000, imm};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 64'd0);

    always_comb begin
        dec_kind = K_ILL;
        dec_ctrl = 4'h0;
        dec_s    = rs_val;
        dec_t    = rt_val;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h24: begin dec_kind = K_ALU; dec_ctrl = 4'h0; end
                    6'h25: begin dec_kind = K_ALU; dec_ctrl = 4'h1; end
                    6'h20, 6'h21: begin dec_kind = K_ALU; dec_ctrl = 4'h2; end
                    6'h22, 6'h23: begin dec_kind = K_ALU; dec_ctrl = 4'h6; end
                    6'h2A: begin dec_kind = K_ALU; dec_ctrl = 4'h7; end
                    6'h27: begin dec_kind = K_ALU; dec_ctrl = 4'hC; end
                    // MFHI/MFLO pass HI or LO through the ALU as an OR with zero
                    6'h10: begin dec_kind = K_ALU; dec_ctrl = 4'h1; dec_s = hi_q; dec_t = '0; end
                    6'h12: begin dec_kind = K_ALU; dec_ctrl = 4'h1; dec_s = lo_q; dec_t = '0; end
                    6'h19: dec_kind = K_MUL;
                    default: dec_kind = K_ILL;
                endcase
            end
            6'h08: begin dec_kind = K_ALU; dec_ctrl = 4'h2; dec_t = imm_sext; end
            6'h0A: begin dec_kind = K_ALU; dec_ctrl = 4'h7; dec_t = imm_sext; end
            6'h0C: begin dec_kind = K_ALU; dec_ctrl = 4'h0; dec_t = imm_zext; end
            6'h0D: begin dec_kind = K_ALU; dec_ctrl = 4'h1; dec_t = imm_zext; end
            6'h04: begin dec_kind = K_ALU; dec_ctrl = 4'h6; end
            default: dec_kind = K_ILL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_s_d    = '0;
        alu_t_d    = '0;
        alu_ctrl_d = '0;
        res_d      = res_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (dec_kind)
                        K_ALU: begin
                            state_d    = S_EXEC;
                            alu_s_d    = dec_s;
                            alu_t_d    = dec_t;
                            alu_ctrl_d = dec_ctrl;
                        end
                        K_MUL: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            mcand_d  = {32'h0, rs_val};
                            mplier_d = rt_val;
                            prod_d   = '0;
                        end
                        default: begin
                            state_d = S_DONE;
                            res_d   = '0;
                            zero_d  = 1'b0;
                            ovf_d   = 1'b0;
                            ill_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                res_d   = alu_result;
                zero_d  = alu_zero;
                ovf_d   = alu_overflow;
                ill_d   = 1'b0;
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    hi_d    = prod_step[63:32];
                    lo_d    = prod_step[31:0];
                    res_d   = prod_step[31:0];
                    zero_d  = (prod_step == 64'd0);
                    ovf_d   = (prod_step[63:32] != 32'd0);
                    ill_d   = 1'b0;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            alu_s_q    <= '0;
            alu_t_q    <= '0;
            alu_ctrl_q <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
        end else begin
            state_q    <= state_d;
            alu_s_q    <= alu_s_d;
            alu_t_q    <= alu_t_d;
            alu_ctrl_q <= alu_ctrl_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
        end
    end

    assign alu_s        = alu_s_q;
    assign alu_t        = alu_t_q;
    assign alu_control  = alu_ctrl_q;
    assign out_valid    = (state_q == S_DONE);
    assign out_result   = res_q;
    assign out_zero     = zero_q;
    assign out_overflow = ovf_q;
    assign out_illegal  = ill_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule
